// File: rtl/outfifo_tx_sequencer.sv
// Drains up to DEPTH words from an output FIFO into a byte-wide UART transmitter,
// sending each word least-significant byte first.
module outfifo_tx_sequencer #(
  parameter int W     = 6,
  parameter int Wc    = 4,
  parameter int DW    = Wc * W,
  parameter int DEPTH = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           transmit_en,
  output logic                           transmit_Ready,
  input  logic                           fifo_empty,
  output logic                           fifo_rd_en,
  input  logic [DW-1:0]                  fifo_dout,
  output logic                           o_Tx_DV,
  output logic [7:0]                     o_Tx_Byte,
  input  logic                           i_Tx_Active,
  input  logic                           i_Tx_Done,
  output logic [$clog2(DEPTH+1)-1:0]     words_sent
);

  localparam int NB  = (DW + 7) / 8;
  localparam int SRW = NB * 8;
  localparam int IW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int WSW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {IDLE, READ, LATCH, LOAD, WAIT, NEXT} state_t;

  state_t           state, state_nxt;
  logic [SRW-1:0]   sr;
  logic [SRW-1:0]   din_ext;
  logic [SRW-1:0]   sr_shift;
  logic [IW-1:0]    idx;
  logic [7:0]       tx_byte;
  logic [WSW-1:0]   wcnt;
  logic             last_byte;
  logic             burst_full;

  assign din_ext    = SRW'(fifo_dout);
  assign sr_shift   = sr >> 8;
  assign last_byte  = (idx == IW'(NB - 1));
  assign burst_full = (wcnt == WSW'(DEPTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Strobes are decoded from the state so they fall the instant reset asserts.
  always_comb begin
    state_nxt      = state;
    transmit_Ready = 1'b0;
    fifo_rd_en     = 1'b0;
    o_Tx_DV        = 1'b0;
    case (state)
      IDLE: begin
        transmit_Ready = 1'b1;
        if (transmit_en) state_nxt = READ;
      end
      READ: begin
        if (fifo_empty || burst_full) begin
          state_nxt = IDLE;
        end else begin
          fifo_rd_en = 1'b1;
          state_nxt  = LATCH;
        end
      end
      LATCH: state_nxt = LOAD;
      LOAD: begin
        if (!i_Tx_Active) begin
          o_Tx_DV   = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (i_Tx_Done) state_nxt = NEXT;
      end
      NEXT: begin
        if (last_byte) state_nxt = READ;
        else           state_nxt = LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // tx_byte is loaded on entry to LOAD, so it mirrors the low byte of sr
  // there and stays put while the UART shifts it out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr      <= '0;
      idx     <= '0;
      tx_byte <= '0;
      wcnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (transmit_en) wcnt <= '0;
        end
        LATCH: begin
          sr      <= din_ext;
          idx     <= '0;
          tx_byte <= din_ext[7:0];
        end
        NEXT: begin
          if (last_byte) begin
            if (wcnt < WSW'(DEPTH)) wcnt <= wcnt + 1'b1;
          end else begin
            sr      <= sr_shift;
            idx     <= idx + 1'b1;
            tx_byte <= sr_shift[7:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign o_Tx_Byte  = tx_byte;
  assign words_sent = wcnt;

endmodule

// File: doc/outfifo_tx_sequencer.md
OUTFIFO_TX_SEQUENCER -- requirements
Module: outfifo_tx_sequencer

Interface
REQ-001 Parameters SHALL be: W, default 6, element width; Wc, default 4, elements per word; DW, default Wc*W, FIFO word width; DEPTH, default 10, maximum words per burst.
REQ-002 NB SHALL be a local constant, ceil(DW/8), bytes per word; 3 at defaults.
REQ-003 Port: clk  in  1  single clock; all logic on its rising edge.
REQ-004 Port: rst  in  1  asynchronous, active-low reset.
REQ-005 Port: transmit_en  in  1  level or pulse; requests one burst drain.
REQ-006 Port: transmit_Ready  out  1  high when idle and accepting transmit_en.
REQ-007 Port: fifo_empty  in  1  output-FIFO empty flag.
REQ-008 Port: fifo_rd_en  out  1  one-cycle FIFO read strobe.
REQ-009 Port: fifo_dout  in  DW  FIFO read data, valid one cycle after fifo_rd_en.
REQ-010 Port: o_Tx_DV  out  1  one-cycle byte-valid strobe to the UART transmitter.
REQ-011 Port: o_Tx_Byte  out  8  byte to transmit; held stable between strobes.
REQ-012 Port: i_Tx_Active  in  1  UART transmitter busy.
REQ-013 Port: i_Tx_Done  in  1  one-cycle pulse when the UART stop bit completes.
REQ-014 Port: words_sent  out  $clog2(DEPTH+1)  words fully transmitted in the current or last burst.

Function
REQ-015 States SHALL be IDLE, READ, LATCH, LOAD, WAIT, NEXT.
REQ-016 IDLE: transmit_Ready=1; transmit_en=1 clears words_sent and moves to READ; otherwise stays.
REQ-017 READ: if fifo_empty=1 or words_sent==DEPTH, go to IDLE with no read; else pulse fifo_rd_en for exactly one cycle and go to LATCH.
REQ-018 LATCH: capture fifo_dout into a DW-bit shift register zero-extended to NB*8 bits, clear byte index, and go to LOAD.
REQ-019 LOAD: wait while i_Tx_Active=1; when it is 0, drive o_Tx_Byte with the low byte of the shift register, pulse o_Tx_DV for one cycle, and go to WAIT.
REQ-020 WAIT: remain until i_Tx_Done=1, then go to NEXT; do not time out.
REQ-021 NEXT: if the byte index is NB-1, increment words_sent and go to READ; else shift the register right 8 bits, increment the byte index, and go to LOAD.
REQ-022 Byte order SHALL be least-significant byte first; padding bits above DW SHALL transmit as 0.
REQ-023 transmit_Ready SHALL be 0 in every state except IDLE; transmit_en outside IDLE is ignored, with no queuing.
REQ-024 A held-high transmit_en SHALL restart a burst on the first IDLE cycle after the previous burst.
REQ-025 Latency: transmit_en sampled in IDLE -> fifo_rd_en 1 cycle later -> first o_Tx_DV 3 cycles after transmit_en if i_Tx_Active=0.
REQ-026 fifo_rd_en and o_Tx_DV SHALL never be high in the same cycle, and neither SHALL be high for two consecutive cycles.
REQ-027 i_Tx_Done seen outside WAIT SHALL be ignored.
REQ-028 words_sent SHALL saturate at DEPTH and hold its value in IDLE until the next accepted transmit_en.

Reset
REQ-029 While rst=0, state SHALL be IDLE, with transmit_Ready=1, fifo_rd_en=0, o_Tx_DV=0, o_Tx_Byte=0, words_sent=0, and the shift register and byte index at 0.
REQ-030 Reset assertion mid-burst SHALL abort immediately; the partially sent word is lost; after release, resume in IDLE.

Verification
REQ-031 FIFO preloaded with 2 words 0x123456, 0xABCDEF, then transmit_en pulse -> bytes 56,34,12,EF,CD,AB in order; words_sent=2; transmit_Ready returns high after the 6th i_Tx_Done.
REQ-032 fifo_empty=1 with transmit_en pulse -> no fifo_rd_en, no o_Tx_DV; transmit_Ready high again 2 cycles later.
REQ-033 FIFO holding 12 words -> exactly 10 fifo_rd_en pulses and 30 o_Tx_DV pulses; words_sent=10; 2 words remain.
REQ-034 i_Tx_Active held high 50 cycles on entering LOAD -> o_Tx_DV is withheld until the cycle after i_Tx_Active falls, then one pulse.
REQ-035 rst pulled low after the 4th byte of a 2-word burst -> all outputs reach reset values asynchronously; no further strobes; a new transmit_en starts again from READ.
REQ-036 transmit_en pulsed during WAIT -> ignored; the burst completes unchanged and no second burst starts.
